// File: rtl/uart_byte_receiver_pkg.sv
// Shared UART definitions: receiver FSM states, frame size and bit-timing helpers.
// Intended for reuse by the matching byte transmitter.
package uart_byte_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int DATA_BITS = 8;

    function automatic int symbol_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int half_time(input int clock_freq, input int baud_rate);
        return symbol_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_byte_receiver_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is chosen to match the input's idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_byte_receiver.sv
// UART byte receiver: 8N1 deserialiser with a one-byte valid/ready holding register
// and single-cycle framing-error / overrun pulses.
module uart_byte_receiver
    import uart_byte_receiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int SYMBOL_TIME = symbol_time(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_TIME   = half_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W       = $clog2(SYMBOL_TIME);
    localparam int IDX_W       = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(SYMBOL_TIME - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TIME - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    rx_state_e        r_state;
    rx_state_e        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [IDX_W-1:0] r_bit_idx;
    logic [IDX_W-1:0] w_bit_idx_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic             w_commit;
    logic             w_frame_err;
    logic             w_rx_s;

    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_framing_error;
    logic             r_overrun;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .i_clk(clk),
        .i_rst(rst),
        .i_d  (serial_in),
        .o_q  (w_rx_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, bit timing and sampling decisions
    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = r_cnt + CNT_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_commit       = 1'b0;
        w_frame_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (!w_rx_s) begin
                    w_next_state = ST_START;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_START: begin
                // Half-bit check rejects short low glitches on an idle line
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state   = ST_DATA;
                        w_bit_idx_next = '0;
                    end
                end else begin
                    w_next_state = ST_START;
                end
            end
            ST_DATA: begin
                if (r_cnt == SYM_LAST) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {w_rx_s, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    if (r_bit_idx == IDX_LAST) begin
                        w_next_state = ST_STOP;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_STOP: begin
                if (r_cnt == SYM_LAST) begin
                    w_cnt_next   = '0;
                    w_next_state = ST_IDLE;
                    if (w_rx_s) begin
                        w_commit = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end else begin
                    w_next_state = ST_STOP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Cycle counter, bit index and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= 8'h00;
        end else begin
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    // Holding register, handshake and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data          <= 8'h00;
            r_valid         <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_framing_error <= w_frame_err;
            r_overrun       <= w_commit & r_valid & ~data_out_ready;
            if (w_commit) begin
                // A byte being consumed this edge frees the slot for the new one
                if (!r_valid || data_out_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= r_valid;
                end
            end else if (r_valid && data_out_ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign framing_error  = r_framing_error;
    assign overrun        = r_overrun;

endmodule
